// File: rtl/seq_alu.sv
// Handshaked, width-parametrised ALU: single-cycle logic/arithmetic plus iterative multiply and shifts.
// Optional accumulator chaining via use_acc is enabled by defining SEQ_ALU_ACC_EN.
module seq_alu #(
    parameter int NBIT = 4
) (
    input  logic            clk,
    input  logic            rst,
`ifdef SEQ_ALU_ACC_EN
    input  logic            use_acc,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      sel,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] result,
    output logic            overflow,
    output logic            zero,
    output logic            carry
);
    localparam int SHW = $clog2(NBIT);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_NOT = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_EQ  = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [2*NBIT-1:0]   work_q, work_d;
    logic [NBIT-1:0]     mcand_q, mcand_d;
    logic [CW-1:0]       count_q, count_d;
    logic [NBIT-1:0]     result_q, result_d;
    logic                overflow_q, overflow_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;

    logic [NBIT-1:0]     op_a;
    logic [NBIT:0]       add_sum;
    logic [NBIT:0]       sub_sum;
    logic [NBIT-1:0]     sc_result;
    logic                sc_carry;
    logic                sc_overflow;
    logic [NBIT:0]       mul_sum;
    logic [2*NBIT:0]     mul_wide;
    logic [2*NBIT-1:0]   mul_next;
    logic [NBIT-1:0]     sh_val;
    logic [NBIT-1:0]     sh_next;
    logic                sh_out;
    logic [NBIT-1:0]     step_result;
    logic                step_carry;
    logic [SHW-1:0]      shamt;
    logic                accept;

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign accept    = in_valid && in_ready;
    assign shamt     = b[SHW-1:0];

    always_comb begin
`ifdef SEQ_ALU_ACC_EN
        op_a = use_acc ? result_q : a;
`else
        op_a = a;
`endif
        add_sum     = {1'b0, op_a} + {1'b0, b};
        sub_sum     = {1'b0, op_a} + {1'b0, ~b} + {{NBIT{1'b0}}, 1'b1};
        sc_result   = '0;
        sc_carry    = 1'b0;
        sc_overflow = 1'b0;
        case (sel)
            OP_ADD: begin
                sc_result   = add_sum[NBIT-1:0];
                sc_carry    = add_sum[NBIT];
                sc_overflow = (op_a[NBIT-1] == b[NBIT-1]) && (add_sum[NBIT-1] != op_a[NBIT-1]);
            end
            OP_SUB: begin
                sc_result   = sub_sum[NBIT-1:0];
                sc_carry    = sub_sum[NBIT];
                sc_overflow = (op_a[NBIT-1] != b[NBIT-1]) && (sub_sum[NBIT-1] != op_a[NBIT-1]);
            end
            OP_NOT:  sc_result = ~op_a;
            OP_AND:  sc_result = op_a & b;
            OP_OR:   sc_result = op_a | b;
            OP_XOR:  sc_result = op_a ^ b;
            OP_SLT:  sc_result = {{(NBIT-1){1'b0}}, ($signed(op_a) < $signed(b))};
            OP_EQ:   sc_result = {{(NBIT-1){1'b0}}, (op_a == b)};
            default: sc_result = '0;
        endcase
    end

    // Multiply keeps {partial_hi, multiplier_lo} in work_q and shifts right once per step.
    always_comb begin
        mul_sum  = {1'b0, work_q[2*NBIT-1:NBIT]} + {1'b0, mcand_q};
        mul_wide = {mul_sum, work_q[NBIT-1:0]};
        mul_next = work_q[0] ? mul_wide[2*NBIT:1] : {1'b0, work_q[2*NBIT-1:1]};
        sh_val   = work_q[NBIT-1:0];
        sh_next  = sh_val;
        sh_out   = 1'b0;
        case (op_q[1:0])
            2'b01: begin
                sh_next = {sh_val[NBIT-2:0], 1'b0};
                sh_out  = sh_val[NBIT-1];
            end
            2'b10: begin
                sh_next = {1'b0, sh_val[NBIT-1:1]};
                sh_out  = sh_val[0];
            end
            2'b11: begin
                sh_next = {sh_val[NBIT-1], sh_val[NBIT-1:1]};
                sh_out  = sh_val[0];
            end
            default: begin
                sh_next = sh_val;
                sh_out  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        work_d      = work_q;
        mcand_d     = mcand_q;
        count_d     = count_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        step_result = '0;
        step_carry  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = sel;
                    if (!sel[3] || sel[2]) begin
                        result_d   = sc_result;
                        carry_d    = sc_carry;
                        overflow_d = sc_overflow;
                        zero_d     = (sc_result == '0);
                        state_d    = ST_DONE;
                    end else if (sel == OP_MUL) begin
                        work_d  = {{NBIT{1'b0}}, b};
                        mcand_d = op_a;
                        count_d = CW'(NBIT);
                        state_d = ST_BUSY;
                    end else if (shamt == '0) begin
                        result_d   = op_a;
                        carry_d    = 1'b0;
                        overflow_d = 1'b0;
                        zero_d     = (op_a == '0);
                        state_d    = ST_DONE;
                    end else begin
                        work_d  = {{NBIT{1'b0}}, op_a};
                        count_d = {1'b0, shamt};
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                count_d = count_q - CW'(1);
                if (op_q == OP_MUL) begin
                    work_d      = mul_next;
                    step_result = mul_next[NBIT-1:0];
                    step_carry  = |mul_next[2*NBIT-1:NBIT];
                end else begin
                    work_d      = {{NBIT{1'b0}}, sh_next};
                    step_result = sh_next;
                    step_carry  = sh_out;
                end
                // Result registers only move on the final step so they stay valid-looking while busy.
                if (count_q == CW'(1)) begin
                    result_d   = step_result;
                    carry_d    = step_carry;
                    overflow_d = 1'b0;
                    zero_d     = (step_result == '0);
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            work_q     <= '0;
            mcand_q    <= '0;
            count_q    <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            work_q     <= work_d;
            mcand_q    <= mcand_d;
            count_q    <= count_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: NBIT=4 instance driven against a reference model and scoreboard,
// plus an NBIT=8 instance for the reset-abort scenario.
module tb_seq_alu;

    typedef struct packed {
        logic [3:0] result;
        logic       overflow;
        logic       zero;
        logic       carry;
        int         steps;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0] sel4, a4, b4, result4;
    logic       overflow4, zero4, carry4;

    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [3:0] sel8;
    logic [7:0] a8, b8, result8;
    logic       overflow8, zero8, carry8;

    int   cyc = 0;
    int   accept_cyc;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t last_exp;

    seq_alu #(.NBIT(4)) dut4 (
        .clk(clk), .rst(rst),
`ifdef SEQ_ALU_ACC_EN
        .use_acc(1'b0),
`endif
        .in_valid(in_valid4), .in_ready(in_ready4), .sel(sel4), .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
        .overflow(overflow4), .zero(zero4), .carry(carry4)
    );

    seq_alu #(.NBIT(8)) dut8 (
        .clk(clk), .rst(rst),
`ifdef SEQ_ALU_ACC_EN
        .use_acc(1'b0),
`endif
        .in_valid(in_valid8), .in_ready(in_ready8), .sel(sel8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .overflow(overflow8), .zero(zero8), .carry(carry8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model for the 4-bit instance, written from arithmetic rather than gate equations.
    function automatic exp_t model4(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int sa, sb_v, si, p, n;
        logic signed [3:0] sv;
        e = '0;
        sa = $signed(a);
        sb_v = $signed(b);
        n = int'(b[1:0]);
        case (sel)
            4'h0: begin
                e.result = a + b;
                e.carry = (int'(a) + int'(b)) > 15;
                si = sa + sb_v;
                e.overflow = (si > 7) || (si < -8);
            end
            4'h1: begin
                e.result = a - b;
                e.carry = (a >= b);
                si = sa - sb_v;
                e.overflow = (si > 7) || (si < -8);
            end
            4'h2: e.result = ~a;
            4'h3: e.result = a & b;
            4'h4: e.result = a | b;
            4'h5: e.result = a ^ b;
            4'h6: e.result = (sa < sb_v) ? 4'd1 : 4'd0;
            4'h7: e.result = (a == b) ? 4'd1 : 4'd0;
            4'h8: begin
                p = int'(a) * int'(b);
                e.result = p[3:0];
                e.carry = (p >> 4) != 0;
                e.steps = 4;
            end
            4'h9, 4'hA, 4'hB: begin
                e.steps = n;
                if (n == 0) begin
                    e.result = a;
                end else if (sel == 4'h9) begin
                    e.result = a << n;
                    e.carry = a[4-n];
                end else if (sel == 4'hA) begin
                    e.result = a >> n;
                    e.carry = a[n-1];
                end else begin
                    sv = a;
                    e.result = sv >>> n;
                    e.carry = a[n-1];
                end
            end
            default: e.result = 4'd0;
        endcase
        e.zero = (e.result == 4'd0);
        return e;
    endfunction

    task automatic applyStimulus(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
        int guard;
        @(negedge clk);
        sel4 = sel;
        a4 = a;
        b4 = b;
        in_valid4 = 1'b1;
        guard = 0;
        while (!in_ready4 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid4 = 1'b0;
        sb.push_back(model4(sel, a, b));
    endtask

    task automatic checkOutput(input string tag, input bit release_out);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!out_valid4 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) check({tag, "_timeout"}, 32'd1, 32'd0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        last_exp = e;
        check({tag, "_latency"}, cyc - accept_cyc, e.steps);
        check({tag, "_result"}, {28'd0, result4}, {28'd0, e.result});
        check({tag, "_flags_ovzc"}, {29'd0, overflow4, zero4, carry4},
              {29'd0, e.overflow, e.zero, e.carry});
        check({tag, "_in_ready"}, {31'd0, in_ready4}, 32'd0);
        if (release_out) begin
            out_ready4 = 1'b1;
            @(posedge clk);
            #1;
            out_ready4 = 1'b0;
            check({tag, "_released"}, {30'd0, out_valid4, in_ready4}, 32'b01);
        end
    endtask

    task automatic wait_out8(input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!out_valid8 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        in_valid4 = 1'b0; out_ready4 = 1'b0; sel4 = '0; a4 = '0; b4 = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; sel8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        check("reset_dut4", {24'd0, out_valid4, result4, overflow4, zero4, carry4}, 32'd0);
        check("reset_dut8", {20'd0, out_valid8, result8, overflow8, zero8, carry8}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", {30'd0, in_ready4, in_ready8}, 32'b11);

        applyStimulus(4'h0, 4'b0111, 4'b0001); checkOutput("add_ovf", 1'b1);
        applyStimulus(4'h1, 4'b0011, 4'b0101); checkOutput("sub_borrow", 1'b1);
        applyStimulus(4'h1, 4'b0101, 4'b0101); checkOutput("sub_zero", 1'b1);
        applyStimulus(4'h8, 4'b0101, 4'b0011); checkOutput("mul_5x3", 1'b1);
        applyStimulus(4'h8, 4'b0110, 4'b0011); checkOutput("mul_6x3", 1'b1);
        applyStimulus(4'hB, 4'b1011, 4'b0010); checkOutput("sra_2", 1'b1);
        applyStimulus(4'h9, 4'b1001, 4'b0100); checkOutput("sll_0", 1'b1);
        applyStimulus(4'h9, 4'b1011, 4'b0011); checkOutput("sll_3", 1'b1);
        applyStimulus(4'hA, 4'b1011, 4'b0001); checkOutput("srl_1", 1'b1);
        applyStimulus(4'h2, 4'b1010, 4'b0000); checkOutput("not", 1'b1);
        applyStimulus(4'h5, 4'b1100, 4'b1010); checkOutput("xor", 1'b1);
        applyStimulus(4'h6, 4'b1000, 4'b0001); checkOutput("slt_neg", 1'b1);
        applyStimulus(4'h7, 4'b0110, 4'b0110); checkOutput("eq", 1'b1);
        applyStimulus(4'hD, 4'b1111, 4'b1111); checkOutput("reserved", 1'b1);

        // Backpressure: result must hold and a pending command must wait.
        applyStimulus(4'h0, 4'b0010, 4'b0011);
        checkOutput("bp_first", 1'b0);
        sel4 = 4'h1; a4 = 4'b1001; b4 = 4'b0100; in_valid4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_result", {28'd0, result4}, {28'd0, last_exp.result});
            check("bp_hold_flags", {29'd0, overflow4, zero4, carry4},
                  {29'd0, last_exp.overflow, last_exp.zero, last_exp.carry});
            check("bp_hold_handshake", {30'd0, out_valid4, in_ready4}, 32'b10);
        end
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        check("bp_release", {30'd0, out_valid4, in_ready4}, 32'b01);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid4 = 1'b0;
        sb.push_back(model4(4'h1, 4'b1001, 4'b0100));
        checkOutput("bp_next", 1'b1);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            checkOutput("random", 1'b1);
        end

        // NBIT=8: give dut8 a nonzero result, then abort a multiply with reset.
        @(negedge clk);
        sel8 = 4'h5; a8 = 8'hA5; b8 = 8'h0F; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        wait_out8("xor8");
        check("xor8_result", {24'd0, result8}, 32'hAA);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        @(negedge clk);
        sel8 = 4'h8; a8 = 8'h0F; b8 = 8'h11; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        check("mul8_busy", {31'd0, out_valid8}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort_clears", {20'd0, out_valid8, result8, overflow8, zero8, carry8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid8) seen++;
        end
        check("abort_no_output", seen, 0);
        @(negedge clk);
        sel8 = 4'h0; a8 = 8'h7F; b8 = 8'h01; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        accept_cyc = cyc;
        wait_out8("add8");
        check("add8_latency", cyc - accept_cyc, 0);
        check("add8_result", {24'd0, result8}, 32'h80);
        check("add8_flags_ovzc", {29'd0, overflow8, zero8, carry8}, 32'b100);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the board-level 4-bit combinational ALU.
- Keeps the 8 single-cycle ops and the overflow/zero/carry flags.
- Adds width parameter NBIT, registered results, and iterative multi-cycle ops: multiply and shifts, one step per cycle.
- Sits between a switch/command front-end and the LED/result consumer; valid/ready on both sides.

Parameters:
- NBIT, 4, operand/result width; power of two, >= 4.
- SHW, $clog2(NBIT), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command valid
- in_ready  out  1  block can accept a command
- sel  in  4  opcode (see Behaviour)
- a  in  NBIT  operand A
- b  in  NBIT  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  NBIT  registered result
- overflow  out  1  registered signed-overflow flag
- zero  out  1  registered zero flag (result == 0)
- carry  out  1  registered carry flag

Behaviour:
- Reset (async, rst=1): state IDLE; result=0, overflow=0, zero=0, carry=0, out_valid=0; in_ready=1 once rst deasserts.
- Asserting rst in any state (incl. BUSY) aborts the operation immediately; no output for the aborted command.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept = in_valid & in_ready, sampled at edge k; a, b, sel are latched at that edge.
- Single-cycle ops (sel[3]=0):
  - 0000 add: A+B.
  - 0001 sub: A+~B+1.
  - 0010 not: ~A.
  - 0011 and.
  - 0100 or.
  - 0101 xor.
  - 0110 slt: {0.., signed A<B}.
  - 0111 eq: {0.., A==B}.
  - Result and flags are registered at edge k, then DONE; out_valid high after edge k (latency 1).
- Multi-cycle ops (sel[3]=1):
  - 1000 mul: unsigned, low NBIT bits; shift-add, NBIT steps.
  - 1001 sll, 1010 srl, 1011 sra: amount = b[SHW-1:0], one bit per step.
  - 11xx: reserved; treated as single-cycle, result=0, flags 0 except zero=1.
- Multi-cycle timing:
  - Edge k: operands latched, step counter loaded, enter BUSY.
  - Steps occur at edges k+1..k+N; enter DONE at edge k+N.
  - N = NBIT for mul; N = shift amount for shifts.
  - Shift amount 0 goes straight to DONE at edge k: result=A, carry=0.
- Flags:
  - zero = (result==0) for all ops.
  - add: carry = carry-out; overflow = signed overflow.
  - sub: carry = carry-out of A+~B+1 (1 = no borrow); overflow = signed overflow.
  - mul: carry = 1 iff the upper NBIT bits of the full 2*NBIT product are nonzero; overflow=0.
  - shifts: carry = last bit shifted out; overflow=0.
  - logic/slt/eq/not: carry=0, overflow=0.
- DONE: result and flags held stable while out_valid & !out_ready (no change under backpressure).
  - out_valid & out_ready at an edge → IDLE, out_valid=0 next cycle.
  - A new command can be accepted at the earliest one cycle later; no same-cycle handoff.
- result and flags keep their last value in IDLE and BUSY; only out_valid qualifies them.
- in_valid while in_ready=0 is ignored; the master must hold the command.

Optional Feature:
- Macro: SEQ_ALU_ACC_EN.
- Defined:
  - Extra input port use_acc (1 bit).
  - When use_acc=1 at accept, operand A is the current registered result instead of port a, enabling chained operations.
  - Reset clears the accumulator (result=0).
- Undefined: no use_acc port; A always comes from port a.

Test Plan:
- NBIT=4, add a=0111 b=0001 → result=1000, overflow=1, carry=0, zero=0, out_valid 1 cycle after accept.
- NBIT=4, sub a=0011 b=0101 → result=1110, carry=0, overflow=0; sub a=0101 b=0101 → result=0000, zero=1, carry=1.
- NBIT=4, mul a=0101 b=0011 → result=1111, carry=0, out_valid exactly 4 cycles after accept edge; mul a=0110 b=0011 → result=0010, carry=1.
- NBIT=4, sra a=1011 b=0010 → result=1110, carry=1, 2-cycle latency; sll amount 0 → result=a, carry=0, latency 1.
- Hold out_ready=0 for 5 cycles after a result → result/flags stable, in_ready=0, new in_valid ignored; release → IDLE, next command accepted.
- NBIT=8 mul 0x0F*0x11 with rst pulsed during BUSY → outputs zero and out_valid=0 immediately; the following add 0x7F+0x01 yields 0x80, overflow=1.
